// File: rtl/keypad_arbiter.sv
// Grants one of two keypad sources an exclusive entry session and forwards its keys to the lock.
// Optional feature: define KEY_ARB_ERROR_RELEASE_EN to end a session on a rising edge of the lock's error flag.
module keypad_arbiter #(
    parameter int CLOCK_FREQ            = 50000000,
    parameter int IDLE_TIMEOUT          = 5 * CLOCK_FREQ,
    parameter int PASSCODE_LENGTH       = 4,
    parameter int TIMEOUT_COUNTER_WIDTH = $clog2(IDLE_TIMEOUT + 1),
    parameter int DIGIT_COUNTER_WIDTH   = $clog2(2 * PASSCODE_LENGTH + 1)
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] keyA,
    input  logic [3:0] keyB,
    input  logic       locked,
    input  logic       error,
    output logic [3:0] key,
    output logic       grantA,
    output logic       grantB,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [TIMEOUT_COUNTER_WIDTH-1:0] TIMEOUT_C =
        TIMEOUT_COUNTER_WIDTH'(IDLE_TIMEOUT);
    localparam logic [DIGIT_COUNTER_WIDTH-1:0] TARGET_LOCKED_C =
        DIGIT_COUNTER_WIDTH'(PASSCODE_LENGTH);
    localparam logic [DIGIT_COUNTER_WIDTH-1:0] TARGET_UNLOCKED_C =
        DIGIT_COUNTER_WIDTH'(2 * PASSCODE_LENGTH);

    state_t                             state_r, state_s;
    logic [3:0]                         key_r, key_s;
    logic                               grant_a_r, grant_a_s;
    logic                               grant_b_r, grant_b_s;
    logic                               busy_r, busy_s;
    logic [DIGIT_COUNTER_WIDTH-1:0]     digit_cnt_r, digit_cnt_s;
    logic [DIGIT_COUNTER_WIDTH-1:0]     target_r, target_s;
    logic [TIMEOUT_COUNTER_WIDTH-1:0]   idle_cnt_r, idle_cnt_s;
    logic [TIMEOUT_COUNTER_WIDTH-1:0]   idle_inc_s;
    logic                               last_b_r, last_b_s;
    logic [3:0]                         src_key_s;
    logic                               press_s;
    logic                               err_rise_s;

`ifdef KEY_ARB_ERROR_RELEASE_EN
    logic error_r;

    // Delayed copy of the lock error flag for edge detection.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            error_r <= 1'b0;
        end else begin
            error_r <= error;
        end
    end

    assign err_rise_s = error & ~error_r;
`else
    logic unused_error_s;
    assign unused_error_s = error;
    assign err_rise_s     = 1'b0;
`endif

    // Next-state, session counters and next output values.
    always_comb begin
        state_s     = state_r;
        key_s       = 4'd0;
        grant_a_s   = 1'b0;
        grant_b_s   = 1'b0;
        digit_cnt_s = digit_cnt_r;
        target_s    = target_r;
        idle_cnt_s  = idle_cnt_r;
        last_b_s    = last_b_r;
        src_key_s   = (state_r == GRANT_B) ? keyB : keyA;
        // key_r holds the granted source's previous key, so 0 -> nonzero is a press
        press_s     = (src_key_s != 4'd0) && (key_r == 4'd0);
        idle_inc_s  = (idle_cnt_r == TIMEOUT_C) ? idle_cnt_r
                                                : idle_cnt_r + TIMEOUT_COUNTER_WIDTH'(1);

        case (state_r)
            IDLE: begin
                if ((keyA != 4'd0) && ((keyB == 4'd0) || last_b_r)) begin
                    state_s     = GRANT_A;
                    key_s       = keyA;
                    grant_a_s   = 1'b1;
                    last_b_s    = 1'b0;
                    target_s    = locked ? TARGET_LOCKED_C : TARGET_UNLOCKED_C;
                    digit_cnt_s = DIGIT_COUNTER_WIDTH'(1);
                    idle_cnt_s  = TIMEOUT_COUNTER_WIDTH'(0);
                end else if (keyB != 4'd0) begin
                    state_s     = GRANT_B;
                    key_s       = keyB;
                    grant_b_s   = 1'b1;
                    last_b_s    = 1'b1;
                    target_s    = locked ? TARGET_LOCKED_C : TARGET_UNLOCKED_C;
                    digit_cnt_s = DIGIT_COUNTER_WIDTH'(1);
                    idle_cnt_s  = TIMEOUT_COUNTER_WIDTH'(0);
                end else begin
                    state_s = IDLE;
                end
            end
            GRANT_A, GRANT_B: begin
                if (press_s) begin
                    idle_cnt_s = TIMEOUT_COUNTER_WIDTH'(0);
                    if (digit_cnt_r != target_r) begin
                        digit_cnt_s = digit_cnt_r + DIGIT_COUNTER_WIDTH'(1);
                    end else begin
                        digit_cnt_s = digit_cnt_r;
                    end
                end else begin
                    idle_cnt_s = idle_inc_s;
                end

                if (((digit_cnt_r == target_r) && (src_key_s == 4'd0)) ||
                    (idle_cnt_s == TIMEOUT_C) || err_rise_s) begin
                    state_s = RELEASE;
                end else begin
                    state_s   = state_r;
                    key_s     = src_key_s;
                    grant_a_s = (state_r == GRANT_A);
                    grant_b_s = (state_r == GRANT_B);
                end
            end
            RELEASE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        busy_s = grant_a_s | grant_b_s;
    end

    // State, counters and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            key_r       <= 4'd0;
            grant_a_r   <= 1'b0;
            grant_b_r   <= 1'b0;
            busy_r      <= 1'b0;
            digit_cnt_r <= '0;
            target_r    <= '0;
            idle_cnt_r  <= '0;
            last_b_r    <= 1'b1;
        end else begin
            state_r     <= state_s;
            key_r       <= key_s;
            grant_a_r   <= grant_a_s;
            grant_b_r   <= grant_b_s;
            busy_r      <= busy_s;
            digit_cnt_r <= digit_cnt_s;
            target_r    <= target_s;
            idle_cnt_r  <= idle_cnt_s;
            last_b_r    <= last_b_s;
        end
    end

    assign key    = key_r;
    assign grantA = grant_a_r;
    assign grantB = grant_b_r;
    assign busy   = busy_r;

endmodule

// File: tb/tb_keypad_arbiter.sv
// Directed scoreboard bench for keypad_arbiter (IDLE_TIMEOUT=20); honours KEY_ARB_ERROR_RELEASE_EN.
module tb_keypad_arbiter;

    logic       clock;
    logic       reset;
    logic [3:0] keyA;
    logic [3:0] keyB;
    logic       locked;
    logic       error;
    logic [3:0] key;
    logic       grantA;
    logic       grantB;
    logic       busy;

    int         total = 0;
    int         bad   = 0;
    logic [6:0] exp_q[$];
    logic [3:0] tog_v = 4'd7;

    keypad_arbiter #(.IDLE_TIMEOUT(20)) dut (
        .clock  (clock),
        .reset  (reset),
        .keyA   (keyA),
        .keyB   (keyB),
        .locked (locked),
        .error  (error),
        .key    (key),
        .grantA (grantA),
        .grantB (grantB),
        .busy   (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic push_exp(input logic [3:0] ek, input logic ega, input logic egb);
        exp_q.push_back({ek, ega, egb, ega | egb});
    endtask

    task automatic check_out(input string tag);
        logic [6:0] exp_v;
        logic [6:0] obs_v;
        exp_v = exp_q.pop_front();
        obs_v = {key, grantA, grantB, busy};
        total++;
        assert (obs_v === exp_v) else begin
            bad++;
            $error("FAIL %s: observed key/gA/gB/busy=%h/%b/%b/%b expected %h/%b/%b/%b",
                   tag, obs_v[6:3], obs_v[2], obs_v[1], obs_v[0],
                   exp_v[6:3], exp_v[2], exp_v[1], exp_v[0]);
        end
    endtask

    // One clock: drive sources, queue the expected outputs, compare after the edge.
    task automatic cyc(input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] ek, input logic ega, input logic egb,
                       input string tag);
        keyA = a;
        keyB = b;
        push_exp(ek, ega, egb);
        @(posedge clock);
        #1;
        check_out(tag);
    endtask

    // One digit on the owning source, optionally toggling the other source 7/0.
    task automatic digit(input logic src_b, input logic [3:0] d, input int hold,
                         input int gap, input logic last, input logic tog,
                         input string tag);
        logic [3:0] other;
        for (int i = 0; i < hold; i++) begin
            tog_v = (tog_v == 4'd7) ? 4'd0 : 4'd7;
            other = tog ? tog_v : 4'd0;
            if (src_b) cyc(other, d, d, 1'b0, 1'b1, tag);
            else       cyc(d, other, d, 1'b1, 1'b0, tag);
        end
        if (last) begin
            tog_v = (tog_v == 4'd7) ? 4'd0 : 4'd7;
            other = tog ? tog_v : 4'd0;
            if (src_b) cyc(other, 4'd0, 4'd0, 1'b0, 1'b0, {tag, "_rel"});
            else       cyc(4'd0, other, 4'd0, 1'b0, 1'b0, {tag, "_rel"});
        end else begin
            for (int i = 0; i < gap; i++) begin
                tog_v = (tog_v == 4'd7) ? 4'd0 : 4'd7;
                other = tog ? tog_v : 4'd0;
                if (src_b) cyc(other, 4'd0, 4'd0, 1'b0, 1'b1, {tag, "_gap"});
                else       cyc(4'd0, other, 4'd0, 1'b1, 1'b0, {tag, "_gap"});
            end
        end
    endtask

    initial begin
        reset  = 1'b0;
        keyA   = 4'd0;
        keyB   = 4'd0;
        locked = 1'b1;
        error  = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        push_exp(4'd0, 1'b0, 1'b0);
        check_out("reset_state");
        reset = 1'b1;
        cyc(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, "idle_after_reset");

        // Single source A on a locked lock: 8,1,4,8
        digit(1'b0, 4'd8, 3, 3, 1'b0, 1'b0, "single_d1");
        digit(1'b0, 4'd1, 3, 3, 1'b0, 1'b0, "single_d2");
        digit(1'b0, 4'd4, 3, 3, 1'b0, 1'b0, "single_d3");
        digit(1'b0, 4'd8, 3, 3, 1'b1, 1'b0, "single_d4");
        cyc(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, "single_idle");

        // Tie right after reset: A wins, the next tie goes to B
        reset = 1'b0;
        #1;
        push_exp(4'd0, 1'b0, 1'b0);
        check_out("reset_async");
        @(posedge clock);
        #1;
        reset = 1'b1;
        cyc(4'd3, 4'd5, 4'd3, 1'b1, 1'b0, "tie1_grant");
        for (int k = 1; k < 20; k++) begin
            if (k < 3) cyc(4'd3, 4'd5, 4'd3, 1'b1, 1'b0, "tie1_hold");
            else       cyc(4'd0, 4'd5, 4'd0, 1'b1, 1'b0, "tie1_wait");
        end
        cyc(4'd0, 4'd5, 4'd0, 1'b0, 1'b0, "tie1_timeout_rel");
        cyc(4'd3, 4'd5, 4'd0, 1'b0, 1'b0, "tie2_idle");
        cyc(4'd3, 4'd5, 4'd5, 1'b0, 1'b1, "tie2_grant_b");
        for (int k = 1; k < 20; k++) cyc(4'd0, 4'd0, 4'd0, 1'b0, 1'b1, "tie2_wait");
        cyc(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, "tie2_timeout_rel");
        cyc(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, "tie2_idle_after");

        // Masking: B toggles 7/0 through an A session, then gets the lock
        tog_v = 4'd7;
        digit(1'b0, 4'd2, 2, 2, 1'b0, 1'b1, "mask_d1");
        digit(1'b0, 4'd6, 2, 2, 1'b0, 1'b1, "mask_d2");
        digit(1'b0, 4'd9, 2, 2, 1'b0, 1'b1, "mask_d3");
        digit(1'b0, 4'd3, 2, 2, 1'b1, 1'b1, "mask_d4");
        cyc(4'd0, 4'd7, 4'd0, 1'b0, 1'b0, "mask_idle");
        cyc(4'd0, 4'd7, 4'd7, 1'b0, 1'b1, "mask_grant_b");
        for (int k = 1; k < 20; k++) cyc(4'd0, 4'd0, 4'd0, 1'b0, 1'b1, "mask_b_wait");
        cyc(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, "mask_b_timeout_rel");
        cyc(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, "mask_b_idle");

        // Unlocked lock: B enters 8 digits in one session
        locked = 1'b0;
        for (int d = 1; d <= 8; d++) begin
            digit(1'b1, 4'(d), 2, 2, (d == 8), 1'b0, "unlocked_digit");
        end
        locked = 1'b1;
        cyc(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, "unlocked_idle");

        // Idle timeout: one press, release exactly 20 cycles later
        cyc(4'd1, 4'd0, 4'd1, 1'b1, 1'b0, "timeout_press");
        for (int k = 1; k < 20; k++) begin
            if (k < 3) cyc(4'd1, 4'd0, 4'd1, 1'b1, 1'b0, "timeout_hold");
            else       cyc(4'd0, 4'd0, 4'd0, 1'b1, 1'b0, "timeout_wait");
        end
        cyc(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, "timeout_rel");
        cyc(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, "timeout_idle");

        // Error pulse after the 2nd digit, then reset mid-session
        digit(1'b0, 4'd5, 2, 2, 1'b0, 1'b0, "err_d1");
        digit(1'b0, 4'd6, 2, 0, 1'b0, 1'b0, "err_d2");
        error = 1'b1;
`ifdef KEY_ARB_ERROR_RELEASE_EN
        cyc(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, "err_release");
        error = 1'b0;
        cyc(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, "err_idle");
`else
        cyc(4'd0, 4'd0, 4'd0, 1'b1, 1'b0, "err_ignored");
        error = 1'b0;
        cyc(4'd0, 4'd0, 4'd0, 1'b1, 1'b0, "err_still_granted");
`endif
        cyc(4'd7, 4'd0, 4'd7, 1'b1, 1'b0, "mid_session_key");
        #2;
        reset = 1'b0;
        #1;
        push_exp(4'd0, 1'b0, 1'b0);
        check_out("reset_mid_session");
        @(posedge clock);
        #1;
        push_exp(4'd0, 1'b0, 1'b0);
        check_out("reset_held");
        reset = 1'b1;
        keyA  = 4'd0;
        cyc(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, "final_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
